// File: rtl/maxpool2x2_stream_if.sv
// Streaming handshake bundle for maxpool2x2_stream: pixel input side and pooled
// output side. The DUT takes the slave view, the traffic source/sink the master view.
interface maxpool2x2_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 FP16 max-pool over one raster-order plane, one row of
// horizontal-pair storage. Optional fused ReLU on the pooled value: MAXPOOL_RELU_EN.
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int CNT_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    maxpool2x2_stream_if.slave   s
);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int IDX_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef logic [DATA_WIDTH-1:0] data_t;

    // Sign-magnitude ordering on raw bits; NaN/Inf get no special treatment.
    function automatic data_t fp_max(input data_t a, input data_t b);
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            return a[DATA_WIDTH-1] ? b : a;
        else if (!a[DATA_WIDTH-1])
            return (a > b) ? a : b;
        else
            return (a < b) ? a : b;
    endfunction

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    data_t            pair_q, pair_d;
    logic             ready_q;
    logic             out_valid_q, out_valid_d;
    data_t            out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    data_t            lb_q [LB_DEPTH];
    logic             lb_we;
    logic [IDX_W-1:0] lb_idx;
    data_t            hmax;
    data_t            pooled;
    logic             accept;

    assign s.in_ready  = ready_q && (!out_valid_q || s.out_ready);
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    assign accept = s.in_valid && s.in_ready;
    assign lb_idx = IDX_W'(col_q >> 1);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        lb_we       = 1'b0;

        hmax   = fp_max(pair_q, s.in_data);
        pooled = fp_max(lb_q[lb_idx], hmax);
`ifdef MAXPOOL_RELU_EN
        if (pooled[DATA_WIDTH-1]) pooled = '0;
`endif

        if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            if (!col_q[0]) begin
                pair_d = s.in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // in_ready guarantees the previous result is gone or leaving now.
                out_valid_d = 1'b1;
                out_data_d  = pooled;
                out_last_d  = (row_q == CNT_W'(IMG_H - 1)) && (col_q == CNT_W'(IMG_W - 1));
            end

            if (col_q == CNT_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == CNT_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            ready_q     <= 1'b1;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset; every entry is written by
    // an even row before an odd row reads it, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_idx] <= hmax;
    end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: an 8x8 instance and a 4x2 instance,
// checked against a window-level reference model. Honours MAXPOOL_RELU_EN.
module tb_maxpool2x2_stream;
    logic clk = 1'b0;
    logic rst_n;
    logic sel;                 // 0 = 8x8 instance, 1 = 4x2 instance
    logic in_valid, out_ready;
    logic [15:0] in_data;
    logic in_ready, out_valid, out_last;
    logic [15:0] out_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    maxpool2x2_stream_if #(.DATA_WIDTH(16)) if_big ();
    maxpool2x2_stream_if #(.DATA_WIDTH(16)) if_small ();

    assign if_big.in_valid    = in_valid && !sel;
    assign if_big.in_data     = in_data;
    assign if_big.out_ready   = out_ready || sel;
    assign if_small.in_valid  = in_valid && sel;
    assign if_small.in_data   = in_data;
    assign if_small.out_ready = out_ready || !sel;

    assign in_ready  = sel ? if_small.in_ready  : if_big.in_ready;
    assign out_valid = sel ? if_small.out_valid : if_big.out_valid;
    assign out_data  = sel ? if_small.out_data  : if_big.out_data;
    assign out_last  = sel ? if_small.out_last  : if_big.out_last;

    maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_W(8), .IMG_H(8), .CNT_W(12)) dut_big (
        .clk(clk), .rst_n(rst_n), .s(if_big.slave));

    maxpool2x2_stream #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(2), .CNT_W(12)) dut_small (
        .clk(clk), .rst_n(rst_n), .s(if_small.slave));

    logic [15:0] px[$];
    logic [15:0] exp_d[$], obs_d[$];
    bit          exp_l[$], obs_l[$];
    int lat_errs, hold_errs, ready_errs, first_acc, last_acc;

    // Total order on FP16 raw patterns: -0 sits just below +0, negatives by magnitude.
    function automatic int fkey(input logic [15:0] v);
        return v[15] ? -int'({17'd0, v[14:0]}) - 1 : int'({17'd0, v[14:0]});
    endfunction

    function automatic logic [15:0] pool4(input logic [15:0] a, b, c, d);
        logic [15:0] m;
        m = a;
        if (fkey(b) > fkey(m)) m = b;
        if (fkey(c) > fkey(m)) m = c;
        if (fkey(d) > fkey(m)) m = d;
`ifdef MAXPOOL_RELU_EN
        if (m[15]) m = 16'h0000;
`endif
        return m;
    endfunction

    task automatic build_expected(input int w, input int h, input int frames);
        int base;
        exp_d.delete();
        exp_l.delete();
        for (int f = 0; f < frames; f++) begin
            base = f * w * h;
            for (int wr = 0; wr < h / 2; wr++)
                for (int wc = 0; wc < w / 2; wc++) begin
                    exp_d.push_back(pool4(px[base + 2*wr*w + 2*wc],     px[base + 2*wr*w + 2*wc + 1],
                                          px[base + (2*wr+1)*w + 2*wc], px[base + (2*wr+1)*w + 2*wc + 1]));
                    exp_l.push_back(wr == h/2 - 1 && wc == w/2 - 1);
                end
        end
    endtask

    function automatic logic [15:0] rand_px();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Streams px[0..n_pix-1], collects outputs, and tracks latency/hold/ready rules.
    task automatic run_stream(input int n_pix, input int n_out, input bit bubble,
                              input bit stall, input int w, input int h);
        int cycle = 0, sent = 0, stall_cnt = 0, f;
        bit pending = 0, prev_vld = 0, held = 0, held_l = 0;
        logic [15:0] held_d = 0;
        obs_d.delete(); obs_l.delete();
        lat_errs = 0; hold_errs = 0; ready_errs = 0; first_acc = -1; last_acc = -1;
        while (obs_d.size() < n_out) begin
            @(negedge clk);
            cycle++;
            if (cycle > 4000) begin
                tests_run++; tests_failed++;
                $display("FAIL timeout: got %0d outputs, required %0d", obs_d.size(), n_out);
                break;
            end
            if (pending && !out_valid) lat_errs++;
            if (out_valid && !prev_vld && !pending) lat_errs++;
            pending = 0;
            if (held && (!out_valid || out_data !== held_d || out_last !== held_l)) hold_errs++;
            if (stall && out_valid && !prev_vld) stall_cnt = 5;
            out_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            in_valid = (sent < n_pix) && !(bubble && cycle[0] == 1'b0);
            in_data  = (sent < n_pix) ? px[sent] : 16'h0;
            #1;
            if (!out_ready && in_ready) ready_errs++;
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_l.push_back(out_last);
            end
            held = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (in_valid && in_ready) begin
                f = sent % (w * h);
                if ((f / w) % 2 == 1 && (f % w) % 2 == 1) pending = 1;
                if (first_acc < 0) first_acc = cycle;
                last_acc = cycle;
                sent++;
            end
            prev_vld = out_valid;
        end
        @(negedge clk);
        in_valid = 0;
        out_ready = 1;
    endtask

    task automatic test_reset();
        sel = 0; in_valid = 0; in_data = 0; out_ready = 1;
        rst_n = 0;
        #12;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        tests_run++;
        if (out_data !== 16'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h, required 0000", out_data); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic small_frame(input string name, input bit bubble, input logic [15:0] e0, input logic [15:0] e1);
        sel = 1;
        run_stream(8, 2, bubble, 0, 4, 2);
        tests_run++;
        if (obs_d.size() !== 2) begin tests_failed++; $display("FAIL %s_count: got %0d, required 2", name, obs_d.size()); end
        else begin
            tests_run++;
            if (obs_d[0] !== e0 || obs_l[0] !== 1'b0) begin
                tests_failed++; $display("FAIL %s_out0: got %h last=%b, required %h last=0", name, obs_d[0], obs_l[0], e0); end
            tests_run++;
            if (obs_d[1] !== e1 || obs_l[1] !== 1'b1) begin
                tests_failed++; $display("FAIL %s_out1: got %h last=%b, required %h last=1", name, obs_d[1], obs_l[1], e1); end
        end
        tests_run++;
        if (lat_errs !== 0) begin tests_failed++; $display("FAIL %s_latency: got %0d violations, required 0", name, lat_errs); end
    endtask

    task automatic test_basic();
        px = '{16'h3C00, 16'h4000, 16'hBC00, 16'hC000, 16'h3800, 16'h3E00, 16'hC200, 16'hBE00};
`ifdef MAXPOOL_RELU_EN
        small_frame("basic", 0, 16'h4000, 16'h0000);
`else
        small_frame("basic", 0, 16'h4000, 16'hBC00);
`endif
    endtask

    task automatic test_mixed_sign();
        px = '{16'h8000, 16'h0000, 16'hBC00, 16'hC000, 16'hC000, 16'hBC00, 16'hC400, 16'hC200};
`ifdef MAXPOOL_RELU_EN
        small_frame("mixed_sign", 0, 16'h0000, 16'h0000);
`else
        small_frame("mixed_sign", 0, 16'h0000, 16'hBC00);
`endif
    endtask

    task automatic test_bubbles();
        px = '{16'h3C00, 16'h4000, 16'hBC00, 16'hC000, 16'h3800, 16'h3E00, 16'hC200, 16'hBE00};
`ifdef MAXPOOL_RELU_EN
        small_frame("bubbles", 1, 16'h4000, 16'h0000);
`else
        small_frame("bubbles", 1, 16'h4000, 16'hBC00);
`endif
    endtask

    task automatic test_backpressure();
        int bad = 0;
        sel = 0;
        px.delete();
        for (int i = 0; i < 64; i++) px.push_back(rand_px());
        build_expected(8, 8, 1);
        run_stream(64, 16, 0, 1, 8, 8);
        tests_run++;
        if (obs_d.size() !== 16) begin tests_failed++; $display("FAIL bp_count: got %0d, required 16", obs_d.size()); end
        for (int i = 0; i < obs_d.size() && i < 16; i++) begin
            tests_run++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                tests_failed++; bad++;
                $display("FAIL bp_out%0d: got %h last=%b, required %h last=%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
        tests_run++;
        if (hold_errs !== 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable cycles, required 0", hold_errs); end
        tests_run++;
        if (ready_errs !== 0) begin tests_failed++; $display("FAIL bp_in_ready: got %0d stalled-ready cycles, required 0", ready_errs); end
        tests_run++;
        if (lat_errs !== 0) begin tests_failed++; $display("FAIL bp_latency: got %0d violations, required 0", lat_errs); end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        px.delete();
        for (int i = 0; i < 128; i++) px.push_back(rand_px());
        build_expected(8, 8, 2);
        run_stream(128, 32, 0, 0, 8, 8);
        tests_run++;
        if (obs_d.size() !== 32) begin tests_failed++; $display("FAIL b2b_count: got %0d, required 32", obs_d.size()); end
        for (int i = 0; i < obs_d.size() && i < 32; i++) begin
            tests_run++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                tests_failed++;
                $display("FAIL b2b_out%0d: got %h last=%b, required %h last=%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
        tests_run++;
        if (last_acc - first_acc !== 127) begin
            tests_failed++; $display("FAIL b2b_throughput: got %0d cycles for 128 pixels, required 128", last_acc - first_acc + 1); end
        tests_run++;
        if (lat_errs !== 0) begin tests_failed++; $display("FAIL b2b_latency: got %0d violations, required 0", lat_errs); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w0;
        int stuck = 0;
        sel = 0;
        px.delete();
        for (int i = 0; i < 11; i++) px.push_back(rand_px());
        w0 = pool4(px[0], px[1], px[8], px[9]);
        out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1; in_data = px[i];
            #1;
            if (!in_ready) stuck++;
        end
        @(negedge clk);
        in_data = px[10];
        #1;
        tests_run++;
        if (stuck !== 0) begin tests_failed++; $display("FAIL rst_mid_accept: got %0d refused pixels, required 0", stuck); end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== w0) begin
            tests_failed++; $display("FAIL rst_mid_pre: got valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, w0); end
        #1;
        rst_n = 0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got valid=%b data=%h last=%b ready=%b, required 0/0000/0/0",
                     out_valid, out_data, out_last, in_ready);
        end
        in_valid = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_release: got in_ready=%b, required 0", in_ready); end

        px.delete();
        for (int i = 0; i < 64; i++) px.push_back(rand_px());
        build_expected(8, 8, 1);
        run_stream(64, 16, 0, 0, 8, 8);
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs_d.size() !== 16 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_count: got %0d outputs valid=%b, required 16 valid=0", obs_d.size(), out_valid); end
        for (int i = 0; i < obs_d.size() && i < 16; i++) begin
            tests_run++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
                tests_failed++;
                $display("FAIL rst_mid_out%0d: got %h last=%b, required %h last=%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed_sign();
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2 / stride-2 max-pool stage. It sits directly upstream of the pairwise FP16 max comparator and is the sequencing and buffering wrapper that feeds it.
- Consumes one FP16 feature-map plane in raster order. Emits one FP16 max per 2x2 window in raster order at half width and half height.
- Window reduction uses the team's FP16 max ordering:
  - sign bits differ: the non-negative operand wins;
  - both non-negative: the larger raw value wins;
  - both negative: the smaller raw value wins.
- A line buffer holds horizontal pair maxima of even rows, so only one row of storage is needed.

Parameters:
- DATA_WIDTH, 16, element width; FP16, sign in bit DATA_WIDTH-1.
- IMG_W, 8, input row length in elements; must be even and at least 2.
- IMG_H, 8, input rows per frame; must be even and at least 2.
- CNT_W, 12, width of the column and row counters; must satisfy 2^CNT_W > max(IMG_W, IMG_H).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, DATA_WIDTH, FP16 pixel, raster order.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- out_data, output, DATA_WIDTH, pooled FP16 value.
- out_last, output, 1, asserted with the final pooled value of a frame.

Behaviour:
- Reset: asynchronous and active-low; reset is already decided as asynchronous active-low on the single clock. While rst_n=0:
  - out_valid=0, out_data=0, out_last=0, in_ready=0;
  - col=0, row=0, pair register cleared, line-buffer contents don't-care.
  - The first rising edge after deassertion drives in_ready=1.
- Reset mid-frame discards any partial frame. The next accepted pixel is treated as (row 0, col 0).
- Input handshake:
  - A beat is accepted when in_valid and in_ready are both high.
  - in_ready = !out_valid || out_ready. Full throughput of 1 pixel/clk when downstream never stalls.
- Counters:
  - col increments on every accept; it wraps from IMG_W-1 to 0 and row increments at the wrap.
  - row wraps from IMG_H-1 to 0 at end of frame. Frames may follow back-to-back with no idle cycle.
- Even col (col[0]=0): register the accepted pixel as pair_a.
- Odd col: compute hmax = max(pair_a, in_data).
  - Even row: write hmax to line buffer entry col>>1 (depth IMG_W/2).
  - Odd row: compute max(linebuf[col>>1], hmax). Register it into out_data with out_valid=1 on the next edge.
- Latency: out_valid rises 1 clock after acceptance of the bottom-right pixel of a window.
- Output hold: out_valid, out_data and out_last stay stable until out_valid && out_ready. They drop on that edge unless a new result is produced on the same edge.
- out_last=1 only for the window with row=IMG_H-1 and col=IMG_W-1.
- Ordering edge cases:
  - +0 (0x0000) beats -0 (0x8000) by the sign rule.
  - Equal inputs return the same value.
  - NaN/Inf are ordered by raw bits; no special handling.
- Stall: while in_ready=0 the counters, pair_a and line buffer are frozen; no input is lost.
- Line-buffer reads and writes in the same cycle never address the same entry: even rows only write, odd rows only read.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: fused ReLU. Any pooled result with sign bit 1 (including -0) is replaced by 0x0000 before it is registered into out_data. Timing and handshake are unchanged.
- Not defined: the pooled value is output unmodified.

Test Plan:
- Basic 4x2 frame: row0 = 0x3C00, 0x4000, 0xBC00, 0xC000; row1 = 0x3800, 0x3E00, 0xC200, 0xBE00 -> out 0x4000 then 0xBC00. out_last is high on the second output, with 1-clk latency after each window's final pixel.
- Mixed sign and zeros: window {0x8000, 0x0000, 0xC000, 0xBC00} -> 0x0000. With MAXPOOL_RELU_EN defined, window {0xBC00, 0xC000, 0xC400, 0xC200} -> 0x0000; without it -> 0xBC00.
- Backpressure: 8x8 frame with random values; out_ready held low for 5 cycles whenever out_valid rises -> in_ready low during the stall, out_data held stable. All 16 outputs match the reference-model max; no pixel dropped.
- Back-to-back frames: two 8x8 frames streamed continuously with in_valid=1 and out_ready=1 -> 32 outputs, out_last on output 16 and output 32, throughput 1 pixel/clk.
- Reset mid-frame: assert rst_n=0 after 11 pixels of an 8x8 frame -> outputs cleared asynchronously. A fresh 8x8 frame after release yields exactly 16 correct outputs.
- Input bubbles: in_valid toggled 1,0,1,0 across a 4x2 frame -> same outputs as the basic case; out_valid never asserts for a partial window.
